// File: rtl/rf_alu_pkg.sv
// rf_alu_pkg: shared ALU opcode, load-immediate mode and PSW definitions.
package rf_alu_pkg;

   typedef enum logic [2:0] {
      ALU_MOV, ALU_ADD, ALU_ADC, ALU_SUB, ALU_SBB, ALU_AND, ALU_OR, ALU_XOR
   } alu_op_e;

   typedef enum logic [1:0] {LI_NONE, LI_LLI, LI_LHI, LI_RSV} li_mode_e;

   typedef struct packed {
      logic c;
      logic z;
      logic n;
      logic v;
   } psw_t;

endpackage

// File: rtl/alu_core.sv
// alu_core: combinational ALU producing result, carry/borrow and signed overflow.
module alu_core
   import rf_alu_pkg::*;
#(
   parameter int DATA_W = 16
) (
   input  logic [DATA_W-1:0] a_i,
   input  logic [DATA_W-1:0] b_i,
   input  logic              cin_i,
   input  alu_op_e           op_i,
   output logic [DATA_W-1:0] y_o,
   output logic              c_o,
   output logic              v_o
);

   localparam int M = DATA_W - 1;

   logic              ci;
   logic [DATA_W:0]   add_w;
   logic [DATA_W:0]   sub_w;

   assign ci    = (op_i == ALU_ADC || op_i == ALU_SBB) & cin_i;
   assign add_w = {1'b0, a_i} + {1'b0, b_i} + {{DATA_W{1'b0}}, ci};
   // the extra top bit of the widened difference is the borrow
   assign sub_w = {1'b0, a_i} - {1'b0, b_i} - {{DATA_W{1'b0}}, ci};

   always_comb begin
      y_o = a_i;
      c_o = 1'b0;
      v_o = 1'b0;
      case (op_i)
         ALU_ADD, ALU_ADC: begin
            y_o = add_w[M:0];
            c_o = add_w[DATA_W];
            v_o = (a_i[M] == b_i[M]) && (add_w[M] != a_i[M]);
         end
         ALU_SUB, ALU_SBB: begin
            y_o = sub_w[M:0];
            c_o = sub_w[DATA_W];
            v_o = (a_i[M] != b_i[M]) && (sub_w[M] != a_i[M]);
         end
         ALU_AND: y_o = a_i & b_i;
         ALU_OR:  y_o = a_i | b_i;
         ALU_XOR: y_o = a_i ^ b_i;
         default: y_o = a_i;
      endcase
   end

endmodule

// File: rtl/regfile_alu_pipe.sv
// regfile_alu_pipe: register file with write-first bypass feeding a two-stage
// EXE/RES ALU pipeline with valid/ready handshakes and a PSW.
module regfile_alu_pipe
   import rf_alu_pkg::*;
#(
   parameter int  DATA_W = 16,
   parameter int  REG_N  = 8,
   parameter int  IMM_W  = 5,
   localparam int AW     = $clog2(REG_N)
) (
   input  logic              clk,
   input  logic              Reset,
   input  logic              id_valid,
   output logic              id_ready,
   input  logic [AW-1:0]     ra_addr,
   input  logic [AW-1:0]     rb_addr,
   input  logic [AW-1:0]     rd_addr,
   input  logic [IMM_W-1:0]  imm,
   input  logic [DATA_W/2-1:0] li_imm,
   input  logic              OprandB,
   input  logic [1:0]        LI,
   input  logic [2:0]        ALUop,
   input  logic              Flag,
   input  logic              WBRF,
   input  logic [AW-1:0]     wb_addr,
   input  logic [DATA_W-1:0] WBData,
   output logic [DATA_W-1:0] OutR,
   output logic              res_valid,
   input  logic              res_ready,
   output logic [DATA_W-1:0] Sum,
   output logic [DATA_W-1:0] IL_EXE,
   output logic [DATA_W-1:0] StData,
   output logic              C,
   output logic              Z,
   output logic              N,
   output logic              V
);

   localparam int HW = DATA_W / 2;

   logic [DATA_W-1:0] rf_q [REG_N];
   logic [DATA_W-1:0] a_q, b_q, d_q;
   alu_op_e           op_q;
   li_mode_e          li_q;
   logic              flag_q;
   logic [HW-1:0]     lim_q;
   logic              ex_valid_q, ex_valid_d;
   logic              res_valid_q, res_valid_d;
   logic [DATA_W-1:0] sum_q, il_q, st_q, il_d;
   psw_t              psw_q, psw_d;

   logic              we, cap, ex_adv, alu_c, alu_v;
   logic [DATA_W-1:0] ra_v, rb_v, rd_v, b_sel, alu_y;

   // a write during reset is dropped, so it must not bypass either
   assign we   = WBRF & ~Reset;
   assign ra_v = (we && wb_addr == ra_addr) ? WBData : rf_q[ra_addr];
   assign rb_v = (we && wb_addr == rb_addr) ? WBData : rf_q[rb_addr];
   assign rd_v = (we && wb_addr == rd_addr) ? WBData : rf_q[rd_addr];
   assign b_sel = OprandB ? {{(DATA_W-IMM_W){1'b0}}, imm} : rb_v;

   assign ex_adv   = ex_valid_q & (~res_valid_q | res_ready);
   assign id_ready = ~Reset & (~ex_valid_q | ~res_valid_q | res_ready);
   assign cap      = id_valid & id_ready;

   alu_core #(.DATA_W(DATA_W)) u_alu (
      .a_i   (a_q),
      .b_i   (b_q),
      .cin_i (psw_q.c),
      .op_i  (op_q),
      .y_o   (alu_y),
      .c_o   (alu_c),
      .v_o   (alu_v)
   );

   always_comb begin
      ex_valid_d  = cap | (ex_valid_q & ~ex_adv);
      res_valid_d = ex_adv | (res_valid_q & ~res_ready);
      il_d        = li_q == LI_LLI ? {{HW{1'b0}}, lim_q} :
                    li_q == LI_LHI ? {lim_q, d_q[HW-1:0]} : '0;
      psw_d       = flag_q ? {alu_c, ~|alu_y, alu_y[DATA_W-1], alu_v} : psw_q;
   end

   always_ff @(posedge clk) begin
      if (Reset) begin
         rf_q        <= '{default: '0};
         ex_valid_q  <= 1'b0;
         res_valid_q <= 1'b0;
         sum_q       <= '0;
         il_q        <= '0;
         st_q        <= '0;
         psw_q       <= '0;
      end else begin
         if (we) rf_q[wb_addr] <= WBData;
         ex_valid_q  <= ex_valid_d;
         res_valid_q <= res_valid_d;
         if (ex_adv) begin
            sum_q <= alu_y;
            il_q  <= il_d;
            st_q  <= d_q;
            psw_q <= psw_d;
         end
      end
   end

   always_ff @(posedge clk) begin
      if (cap) begin
         a_q    <= ra_v;
         b_q    <= b_sel;
         d_q    <= rd_v;
         op_q   <= alu_op_e'(ALUop);
         li_q   <= li_mode_e'(LI);
         flag_q <= Flag;
         lim_q  <= li_imm;
      end
   end

   assign OutR      = ra_v;
   assign res_valid = res_valid_q;
   assign Sum       = sum_q;
   assign IL_EXE    = il_q;
   assign StData    = st_q;
   assign C         = psw_q.c;
   assign Z         = psw_q.z;
   assign N         = psw_q.n;
   assign V         = psw_q.v;

endmodule
